// File: rtl/exception_sequencer.sv
// exception_sequencer
// Exception entry/return sequencer. When a retiring instruction carries an
// enabled cause, it pulses jisr, latches the cause context, writes the four
// exception SPRs (ESR, ECA, EPC, EDATA), redirects the PC to the handler, and
// stalls fetch/issue while it does so. An eret retiring in the handler
// restores sr and mode and returns to the latched EPC. Cause 0 aborts any
// sequence in progress and restarts exception entry.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   ca[22:0]              level cause lines, index 0 = highest priority
//   sr[31:0]              status register (sr[i] enables maskable cause i)
//   mode                  current mode, 1 = user
//   instr_done, eret      retire strobe and return-from-exception flag
//   pc, next_pc, ea       retiring PC, its successor, effective address
//   jisr                  one-cycle exception-entry pulse
//   il, rpt               latched interrupt level and repeat flag
//   spr_we/sel/wdata      SPR write port (0=ESR 1=ECA 2=EPC 3=EDATA)
//   pc_load, pc_target    PC redirect
//   sr_clear, sr_restore  sr clear / restore-from-ESR strobes
//   mode_out              mode to apply
//   busy                  stalls fetch/issue
module exception_sequencer #(
    parameter logic [31:0] SISR_ADDR = 32'h0000_0100,
    parameter int          NMASK_LO  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [22:0] ca,
    input  logic [31:0] sr,
    input  logic        mode,
    input  logic        instr_done,
    input  logic        eret,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic [31:0] ea,
    output logic        jisr,
    output logic [4:0]  il,
    output logic        rpt,
    output logic        spr_we,
    output logic [1:0]  spr_sel,
    output logic [31:0] spr_wdata,
    output logic        pc_load,
    output logic [31:0] pc_target,
    output logic        sr_clear,
    output logic        sr_restore,
    output logic        mode_out,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RESTORE = 3'd4
    } state_t;

    // Lowest set index of the cause vector (index 0 has highest priority).
    function automatic logic [4:0] lowest_index(input logic [22:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 22; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t      state_r;
    logic [1:0]  cnt_r;
    logic [22:0] mca_r;
    logic [31:0] sr_r;
    logic        mode_r;
    logic [31:0] ea_r;
    logic [31:0] epc_r;

    logic [22:0] mca_s;
    logic [4:0]  il_s;
    logic        rpt_s;
    logic [31:0] epc_s;
    logic        enter_s;
    logic [1:0]  cnt_next_s;
    logic [31:0] save_data_s;

    // Cause masking, priority resolution and entry decision.
    always_comb begin
        mca_s = 23'd0;
        for (int i = 0; i < 23; i++) begin
            if (i < NMASK_LO) begin
                mca_s[i] = ca[i];
            end else begin
                mca_s[i] = ca[i] & sr[i];
            end
        end
        il_s  = lowest_index(mca_s);
        // Causes 3 and 4 re-execute the faulting instruction on return.
        rpt_s = (il_s == 5'd3) || (il_s == 5'd4);
        epc_s = rpt_s ? pc : next_pc;
        // Outside IDLE only cause 0 may (re)start exception entry.
        if (state_r == ST_IDLE) begin
            enter_s = instr_done && (mca_s != 23'd0);
        end else begin
            enter_s = instr_done && mca_s[0];
        end
    end

    // SPR word for the next save slot, taken from the latched context.
    always_comb begin
        cnt_next_s = cnt_r + 2'd1;
        case (cnt_next_s)
            2'd1:    save_data_s = {9'd0, mca_r};
            2'd2:    save_data_s = epc_r;
            2'd3:    save_data_s = ea_r;
            default: save_data_s = sr_r;
        endcase
    end

    // Sequencer FSM with registered outputs aligned to the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 2'd0;
            mca_r      <= 23'd0;
            sr_r       <= 32'd0;
            mode_r     <= 1'b0;
            ea_r       <= 32'd0;
            epc_r      <= 32'd0;
            jisr       <= 1'b0;
            il         <= 5'd0;
            rpt        <= 1'b0;
            spr_we     <= 1'b0;
            spr_sel    <= 2'd0;
            spr_wdata  <= 32'd0;
            pc_load    <= 1'b0;
            pc_target  <= 32'd0;
            sr_clear   <= 1'b0;
            sr_restore <= 1'b0;
            mode_out   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            jisr       <= 1'b0;
            spr_we     <= 1'b0;
            pc_load    <= 1'b0;
            sr_clear   <= 1'b0;
            sr_restore <= 1'b0;
            if (enter_s) begin
                // First SAVE cycle writes ESR from the live sr, which is being latched now.
                state_r   <= ST_SAVE;
                cnt_r     <= 2'd0;
                jisr      <= 1'b1;
                il        <= il_s;
                rpt       <= rpt_s;
                mca_r     <= mca_s;
                sr_r      <= sr;
                mode_r    <= mode;
                ea_r      <= ea;
                epc_r     <= epc_s;
                spr_we    <= 1'b1;
                spr_sel   <= 2'd0;
                spr_wdata <= sr;
                mode_out  <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        mode_out <= mode;
                        busy     <= 1'b0;
                    end
                    ST_SAVE: begin
                        if (cnt_r == 2'd3) begin
                            state_r   <= ST_VECTOR;
                            cnt_r     <= 2'd0;
                            pc_load   <= 1'b1;
                            pc_target <= SISR_ADDR;
                            sr_clear  <= 1'b1;
                            mode_out  <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            cnt_r     <= cnt_next_s;
                            spr_we    <= 1'b1;
                            spr_sel   <= cnt_next_s;
                            spr_wdata <= save_data_s;
                            busy      <= 1'b1;
                        end
                    end
                    ST_VECTOR: begin
                        state_r  <= ST_HANDLER;
                        mode_out <= 1'b0;
                        busy     <= 1'b0;
                    end
                    ST_HANDLER: begin
                        if (instr_done && eret) begin
                            state_r    <= ST_RESTORE;
                            pc_load    <= 1'b1;
                            pc_target  <= epc_r;
                            sr_restore <= 1'b1;
                            mode_out   <= mode_r;
                            busy       <= 1'b1;
                        end else begin
                            mode_out <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                    ST_RESTORE: begin
                        state_r  <= ST_IDLE;
                        mode_out <= mode;
                        busy     <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= 2'd0;
                        mode_out <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed testbench for exception_sequencer: syscall, page fault with repeat,
// masking, priority, cause-0 abort and precedence over eret, eret ignored in
// IDLE, return path, and reset in the middle of the SPR save.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] ca;
    logic [31:0] sr;
    logic        mode;
    logic        instr_done;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] ea;
    logic        jisr;
    logic [4:0]  il;
    logic        rpt;
    logic        spr_we;
    logic [1:0]  spr_sel;
    logic [31:0] spr_wdata;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        sr_clear;
    logic        sr_restore;
    logic        mode_out;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    exception_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .ca         (ca),
        .sr         (sr),
        .mode       (mode),
        .instr_done (instr_done),
        .eret       (eret),
        .pc         (pc),
        .next_pc    (next_pc),
        .ea         (ea),
        .jisr       (jisr),
        .il         (il),
        .rpt        (rpt),
        .spr_we     (spr_we),
        .spr_sel    (spr_sel),
        .spr_wdata  (spr_wdata),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .sr_clear   (sr_clear),
        .sr_restore (sr_restore),
        .mode_out   (mode_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs describing the entry are already driven; walk entry, SAVE, VECTOR
    // and arrive in HANDLER, checking every step.
    task automatic entry_seq(input logic [4:0] e_il, input logic e_rpt, input logic [31:0] e_esr,
                             input logic [31:0] e_eca, input logic [31:0] e_epc, input logic [31:0] e_ea);
        tick();
        instr_done = 1'b0;
        eret       = 1'b0;
        ca         = 23'd0;
        check_eq("jisr_on", {31'd0, jisr}, 32'd1);
        check_eq("il", {27'd0, il}, {27'd0, e_il});
        check_eq("rpt", {31'd0, rpt}, {31'd0, e_rpt});
        check_eq("entry_no_pcload", {31'd0, pc_load}, 32'd0);
        check_eq("save0_we", {31'd0, spr_we}, 32'd1);
        check_eq("save0_sel", {30'd0, spr_sel}, 32'd0);
        check_eq("esr", spr_wdata, e_esr);
        check_eq("save0_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("jisr_off", {31'd0, jisr}, 32'd0);
        check_eq("save1_sel", {30'd0, spr_sel}, 32'd1);
        check_eq("eca", spr_wdata, e_eca);
        tick();
        check_eq("save2_sel", {30'd0, spr_sel}, 32'd2);
        check_eq("epc", spr_wdata, e_epc);
        tick();
        check_eq("save3_we", {31'd0, spr_we}, 32'd1);
        check_eq("save3_sel", {30'd0, spr_sel}, 32'd3);
        check_eq("edata", spr_wdata, e_ea);
        tick();
        check_eq("vec_we", {31'd0, spr_we}, 32'd0);
        check_eq("vec_pcload", {31'd0, pc_load}, 32'd1);
        check_eq("vec_target", pc_target, 32'h0000_0100);
        check_eq("vec_srclr", {31'd0, sr_clear}, 32'd1);
        check_eq("vec_mode", {31'd0, mode_out}, 32'd0);
        check_eq("vec_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("hdl_pcload", {31'd0, pc_load}, 32'd0);
        check_eq("hdl_srclr", {31'd0, sr_clear}, 32'd0);
        check_eq("hdl_busy", {31'd0, busy}, 32'd0);
        check_eq("hdl_mode", {31'd0, mode_out}, 32'd0);
    endtask

    // From HANDLER, retire an eret and check RESTORE then IDLE.
    task automatic return_seq(input logic [31:0] e_epc, input logic e_mode);
        instr_done = 1'b1;
        eret       = 1'b1;
        tick();
        instr_done = 1'b0;
        eret       = 1'b0;
        check_eq("rst_pcload", {31'd0, pc_load}, 32'd1);
        check_eq("rst_target", pc_target, e_epc);
        check_eq("rst_srrest", {31'd0, sr_restore}, 32'd1);
        check_eq("rst_mode", {31'd0, mode_out}, {31'd0, e_mode});
        check_eq("rst_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("idle_pcload", {31'd0, pc_load}, 32'd0);
        check_eq("idle_srrest", {31'd0, sr_restore}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_mode", {31'd0, mode_out}, {31'd0, mode});
    endtask

    initial begin
        int jisr_cnt;
        int we_cnt;
        int load_cnt;
        reset      = 1'b1;
        ca         = 23'd0;
        sr         = 32'd0;
        mode       = 1'b0;
        instr_done = 1'b0;
        eret       = 1'b0;
        pc         = 32'd0;
        next_pc    = 32'd0;
        ea         = 32'd0;
        tick();
        tick();
        check_eq("reset_jisr", {31'd0, jisr}, 32'd0);
        check_eq("reset_we", {31'd0, spr_we}, 32'd0);
        check_eq("reset_pcload", {31'd0, pc_load}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_il", {27'd0, il}, 32'd0);
        check_eq("reset_wdata", spr_wdata, 32'd0);
        check_eq("reset_target", pc_target, 32'd0);
        reset = 1'b0;
        tick();

        // Syscall: unmaskable cause 5, sr=0.
        ca = 23'h20; pc = 32'h40; next_pc = 32'h44; ea = 32'hdead_beef; sr = 32'd0; mode = 1'b0;
        instr_done = 1'b1;
        entry_seq(5'd5, 1'b0, 32'd0, 32'h20, 32'h44, 32'hdead_beef);
        return_seq(32'h44, 1'b0);

        // Page fault on fetch from user mode: repeat, EPC = pc.
        ca = 23'h08; pc = 32'h80; next_pc = 32'h84; ea = 32'h1234; mode = 1'b1;
        instr_done = 1'b1;
        entry_seq(5'd3, 1'b1, 32'd0, 32'h08, 32'h80, 32'h1234);
        return_seq(32'h80, 1'b1);
        mode = 1'b0;

        // Masked cause 10 must not enter for 10 cycles.
        ca = 23'h400; sr = 32'd0; pc = 32'h200; next_pc = 32'h204; ea = 32'h55;
        instr_done = 1'b1;
        jisr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (jisr || busy) jisr_cnt++;
        end
        check_eq("masked_no_entry", jisr_cnt, 32'd0);
        sr = 32'h400;
        entry_seq(5'd10, 1'b0, 32'h400, 32'h400, 32'h204, 32'h55);
        return_seq(32'h204, 1'b0);

        // Priority: causes 3 and 10 together.
        ca = 23'h408; sr = 32'h400; pc = 32'h300; next_pc = 32'h304; ea = 32'h66;
        instr_done = 1'b1;
        entry_seq(5'd3, 1'b1, 32'h400, 32'h408, 32'h300, 32'h66);

        // Cause 0 beats a simultaneous eret in HANDLER.
        ca = 23'h1; eret = 1'b1; sr = 32'd0; pc = 32'h500; next_pc = 32'h504; ea = 32'h77;
        instr_done = 1'b1;
        entry_seq(5'd0, 1'b0, 32'd0, 32'h1, 32'h504, 32'h77);
        return_seq(32'h504, 1'b0);

        // Cause 0 aborts a save in progress and restarts at ESR.
        ca = 23'h20; sr = 32'd0; pc = 32'h600; next_pc = 32'h604; ea = 32'h88;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0; ca = 23'd0;
        tick();
        check_eq("abort_pre_sel", {30'd0, spr_sel}, 32'd1);
        ca = 23'h1; sr = 32'h0000_0abc; pc = 32'h700; next_pc = 32'h704; ea = 32'h99;
        instr_done = 1'b1;
        entry_seq(5'd0, 1'b0, 32'h0000_0abc, 32'h1, 32'h704, 32'h99);
        return_seq(32'h704, 1'b0);
        sr = 32'd0;

        // eret in IDLE is ignored.
        instr_done = 1'b1; eret = 1'b1;
        tick();
        tick();
        instr_done = 1'b0; eret = 1'b0;
        check_eq("idle_eret_pcload", {31'd0, pc_load}, 32'd0);
        check_eq("idle_eret_busy", {31'd0, busy}, 32'd0);

        // Reset at SAVE cnt=2.
        ca = 23'h20; pc = 32'h900; next_pc = 32'h904; ea = 32'haa;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0; ca = 23'd0;
        tick();
        tick();
        check_eq("pre_reset_sel", {30'd0, spr_sel}, 32'd2);
        reset = 1'b1;
        #1;
        check_eq("midreset_we", {31'd0, spr_we}, 32'd0);
        check_eq("midreset_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        we_cnt = 0;
        load_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (spr_we) we_cnt++;
            if (pc_load || busy) load_cnt++;
        end
        check_eq("post_reset_we", we_cnt, 32'd0);
        check_eq("post_reset_pcload", load_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 Parameter SISR_ADDR, default 32'h0000_0100, is the handler entry address loaded into the PC on exception entry.
REQ-002 Parameter NMASK_LO, default 6, is the lowest maskable cause index; causes 0..NMASK_LO-1 cannot be masked.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high, with ports clk and reset.
REQ-004 Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ca  in  23  level cause lines, index 0 = highest priority
- sr  in  32  status register; sr[i]=1 enables cause i, for i >= NMASK_LO
- mode  in  1  current mode, 1 = user
- instr_done  in  1  retire strobe; causes and eret are sampled only when it is high
- eret  in  1  return-from-exception retiring
- pc, next_pc, ea  in  32 each  retiring PC, its successor, and effective address
- jisr  out  1  one-cycle exception-entry pulse
- il  out  5  latched interrupt level
- rpt  out  1  latched repeat flag
- spr_we  out  1  SPR write strobe
- spr_sel  out  2  0=ESR, 1=ECA, 2=EPC, 3=EDATA
- spr_wdata  out  32  SPR write data
- pc_load  out  1  PC redirect strobe
- pc_target  out  32  redirect address
- sr_clear  out  1  clears sr
- sr_restore  out  1  restores sr from ESR
- mode_out  out  1  mode to apply
- busy  out  1  stalls fetch/issue

Function
REQ-005 Masked cause: mca[i] = ca[i] for i < NMASK_LO; mca[i] = ca[i] & sr[i] otherwise.
REQ-006 States SHALL be IDLE, SAVE, VECTOR, HANDLER and RESTORE, with a 2-bit save counter cnt.
REQ-007 IDLE: when instr_done=1 and mca != 0, the block SHALL do all of the following in that cycle, then enter SAVE with cnt=0:
- assert jisr for one cycle
- latch il = lowest set index
- latch rpt = (il==3 || il==4)
- latch mca, sr, mode, ea, and epc = rpt ? pc : next_pc
REQ-008 SAVE: the block SHALL keep spr_we=1 and spr_sel=cnt for 4 consecutive cycles, with spr_wdata as follows:
- cnt=0: latched sr
- cnt=1: {9'b0, latched mca}
- cnt=2: latched epc
- cnt=3: latched ea
REQ-009 SAVE SHALL go to VECTOR after cnt=3, and cnt SHALL wrap to 0.
REQ-010 VECTOR: for one cycle, pc_load=1, pc_target=SISR_ADDR, sr_clear=1 and mode_out=0; the next state is HANDLER.
REQ-011 HANDLER: busy=0 and mode_out=0; causes 1..22 are ignored; instr_done=1 with eret=1 SHALL enter RESTORE.
REQ-012 RESTORE: for one cycle, pc_load=1, pc_target=latched epc, sr_restore=1 and mode_out=latched mode; the next state is IDLE.
REQ-013 busy SHALL be 1 in SAVE, VECTOR and RESTORE, and 0 in IDLE and HANDLER.
REQ-014 Outside IDLE, ca[0]=1 with instr_done=1 SHALL re-enter exception entry as in REQ-007 with il=0, aborting any save in progress (cnt restarts at 0).
REQ-015 ca[0] SHALL take precedence over a simultaneous eret in HANDLER.
REQ-016 eret in IDLE SHALL be ignored, because illegal-eret detection is done upstream.
REQ-017 Simultaneous causes SHALL resolve as follows:
- il is the lowest set index
- ECA still records all set mca bits
REQ-018 In IDLE, mode_out SHALL follow the mode input.
REQ-019 jisr, spr_we, pc_load, sr_clear and sr_restore SHALL be registered, and none SHALL be high for more than the cycles stated above.

Reset
REQ-020 While reset=1, the block SHALL asynchronously force:
- state = IDLE, cnt = 0
- jisr, spr_we, pc_load, sr_clear, sr_restore, busy = 0
- il = 0, rpt = 0, spr_sel = 0, spr_wdata = 0, pc_target = 0
- mode_out = 0, and all latches = 0
REQ-021 Reset mid-sequence SHALL abandon the sequence with no further SPR writes or PC loads.

Verification
REQ-022 Syscall: ca[5]=1, pc=0x40, next_pc=0x44, sr=0, instr_done=1. Required:
- jisr for 1 cycle, il=5, rpt=0
- SPR writes ESR=0, ECA=0x20, EPC=0x44, EDATA=ea
- then pc_load with pc_target=0x100 and mode_out=0
REQ-023 Page fault on fetch: ca[3]=1, pc=0x80. Required: rpt=1 and EPC=0x80.
REQ-024 Masking:
- ca[10]=1 with sr[10]=0 -> no jisr for 10 cycles
- then sr[10]=1 -> il=10, ECA=0x400
REQ-025 Priority: ca[3] and ca[10] both set, with sr[10]=1. Required: il=3 and ECA=0x408.
REQ-026 Return: mode=1 at entry, then eret with instr_done in HANDLER. Required:
- RESTORE cycle with pc_target=latched EPC, sr_restore=1, mode_out=1
- then IDLE with busy=0
REQ-027 Reset mid-save: assert reset at SAVE cnt=2. Required:
- spr_we=0 immediately
- state IDLE
- no pc_load after reset is released
